cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between N functional-unit result producers (ALU, load/store buffer, branch unit).
- Each producer has a one-entry holding buffer; one buffered result per cycle is granted round-robin and broadcast on a registered CDB output.
- The CDB output feeds the reservation stations and the reorder buffer, which later commits to the register file.
- A flush from the reorder buffer discards all buffered and in-flight results.

---
 rtl/cdb_arbiter.sv | 127 ++++++++++++
 tb/tb_cdb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per result producer,
// round-robin grant of one buffered result per cycle onto a registered CDB.
module cdb_arbiter #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [N_REQ-1:0]         req_valid_in,
    input  logic [N_REQ*TAG_W-1:0]   req_tag_in,
    input  logic [N_REQ*DATA_W-1:0]  req_value_in,
    output logic [N_REQ-1:0]         req_ready_out,
    input  logic                     rob_flush_in,
    output logic                     cdb_valid_out,
    output logic [TAG_W-1:0]         cdb_tag_out,
    output logic [DATA_W-1:0]        cdb_value_out,
    output logic [$clog2(N_REQ)-1:0] cdb_src_out
);

    localparam int unsigned SRC_W = $clog2(N_REQ);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } result_t;

    logic [N_REQ-1:0] hold_v_q, hold_v_d;
    result_t          hold_q [N_REQ];
    result_t          hold_d [N_REQ];
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic             cdb_vld_q, cdb_vld_d;
    result_t          cdb_q, cdb_d;
    logic [SRC_W-1:0] src_q, src_d;

    logic             grant_vld_c;
    logic [SRC_W-1:0] grant_idx_c;
    logic [N_REQ-1:0] grant_c;
    logic [SRC_W-1:0] scan_idx;

    // Round-robin pick: first full buffer at or after ptr, with wrap-around
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (32'(ptr_q) + k >= N_REQ) begin
                scan_idx = SRC_W'(32'(ptr_q) + k - N_REQ);
            end else begin
                scan_idx = SRC_W'(32'(ptr_q) + k);
            end
            if (!grant_vld_c && hold_v_q[scan_idx] && rdy_in && !rob_flush_in) begin
                grant_vld_c = 1'b1;
                grant_idx_c = scan_idx;
            end
        end
    end

    // A buffer being drained this cycle can be refilled at the same edge
    always_comb begin
        grant_c       = '0;
        req_ready_out = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_c[i]       = grant_vld_c && (grant_idx_c == SRC_W'(i));
            req_ready_out[i] = !rst_in && rdy_in && !rob_flush_in &&
                               (!hold_v_q[i] || grant_c[i]);
        end
    end

    always_comb begin
        hold_v_d  = hold_v_q;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        cdb_vld_d = cdb_vld_q;
        cdb_d     = cdb_q;
        src_d     = src_q;
        if (rdy_in) begin
            if (rob_flush_in) begin
                hold_v_d  = '0;
                cdb_vld_d = 1'b0;
            end else begin
                cdb_vld_d = grant_vld_c;
                if (grant_vld_c) begin
                    cdb_d                 = hold_q[grant_idx_c];
                    src_d                 = grant_idx_c;
                    hold_v_d[grant_idx_c] = 1'b0;
                    ptr_d = (grant_idx_c == SRC_W'(N_REQ - 1)) ? '0
                                                               : grant_idx_c + SRC_W'(1);
                end
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    if (req_valid_in[i] && req_ready_out[i]) begin
                        hold_v_d[i]   = 1'b1;
                        hold_d[i].tag = req_tag_in[i*TAG_W +: TAG_W];
                        hold_d[i].val = req_value_in[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hold_v_q  <= '0;
            ptr_q     <= '0;
            cdb_vld_q <= 1'b0;
            cdb_q     <= '0;
            src_q     <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            hold_v_q  <= hold_v_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
            cdb_vld_q <= cdb_vld_d;
            cdb_q     <= cdb_d;
            src_q     <= src_d;
        end
    end

    assign cdb_valid_out = cdb_vld_q;
    assign cdb_tag_out   = cdb_q.tag;
    assign cdb_value_out = cdb_q.val;
    assign cdb_src_out   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: N_REQ=3, DATA_W=32, TAG_W=4.
module tb_cdb_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [2:0]  req_valid_in = '0;
    logic [11:0] req_tag_in = '0;
    logic [95:0] req_value_in = '0;
    logic [2:0]  req_ready_out;
    logic        rob_flush_in = 1'b0;
    logic        cdb_valid_out;
    logic [3:0]  cdb_tag_out;
    logic [31:0] cdb_value_out;
    logic [1:0]  cdb_src_out;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    cdb_arbiter #(.N_REQ(3), .DATA_W(32), .TAG_W(4)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .req_valid_in  (req_valid_in),
        .req_tag_in    (req_tag_in),
        .req_value_in  (req_value_in),
        .req_ready_out (req_ready_out),
        .rob_flush_in  (rob_flush_in),
        .cdb_valid_out (cdb_valid_out),
        .cdb_tag_out   (cdb_tag_out),
        .cdb_value_out (cdb_value_out),
        .cdb_src_out   (cdb_src_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic offer(input int p, input logic [3:0] t, input logic [31:0] v);
        req_valid_in[p]          = 1'b1;
        req_tag_in[p*4 +: 4]     = t;
        req_value_in[p*32 +: 32] = v;
    endtask

    task automatic idle();
        req_valid_in = '0;
    endtask

    task automatic test_reset();
        #1 rst_in = 1'b1;
        #2;
        chk_cnt++; if (req_ready_out !== 3'b000) $display("FAIL rst_ready got %b exp 000", req_ready_out); else pass_cnt++;
        chk_cnt++; if (cdb_valid_out !== 1'b0) $display("FAIL rst_valid got %b exp 0", cdb_valid_out); else pass_cnt++;
        chk_cnt++; if (cdb_tag_out !== 4'd0) $display("FAIL rst_tag got %0d exp 0", cdb_tag_out); else pass_cnt++;
        chk_cnt++; if (cdb_value_out !== 32'd0) $display("FAIL rst_value got %h exp 0", cdb_value_out); else pass_cnt++;
        chk_cnt++; if (cdb_src_out !== 2'd0) $display("FAIL rst_src got %0d exp 0", cdb_src_out); else pass_cnt++;
        tick();
        rst_in = 1'b0;
        #1;
        chk_cnt++; if (req_ready_out !== 3'b111) $display("FAIL post_rst_ready got %b exp 111", req_ready_out); else pass_cnt++;
    endtask

    task automatic test_single();
        offer(1, 4'd5, 32'hDEADBEEF);
        #1;
        chk_cnt++; if (req_ready_out[1] !== 1'b1) $display("FAIL single_ready got %b exp 1", req_ready_out[1]); else pass_cnt++;
        tick();
        idle();
        chk_cnt++; if (cdb_valid_out !== 1'b0) $display("FAIL single_nobypass got %b exp 0", cdb_valid_out); else pass_cnt++;
        tick();
        chk_cnt++; if (cdb_valid_out !== 1'b1) $display("FAIL single_valid got %b exp 1", cdb_valid_out); else pass_cnt++;
        chk_cnt++; if (cdb_tag_out !== 4'd5) $display("FAIL single_tag got %0d exp 5", cdb_tag_out); else pass_cnt++;
        chk_cnt++; if (cdb_value_out !== 32'hDEADBEEF) $display("FAIL single_value got %h exp deadbeef", cdb_value_out); else pass_cnt++;
        chk_cnt++; if (cdb_src_out !== 2'd1) $display("FAIL single_src got %0d exp 1", cdb_src_out); else pass_cnt++;
        tick();
        chk_cnt++; if (cdb_valid_out !== 1'b0) $display("FAIL single_drop got %b exp 0", cdb_valid_out); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_tag;
        rst_in = 1'b1;
        #1 rst_in = 1'b0;
        offer(0, 4'd1, 32'h0000_00A1);
        offer(1, 4'd2, 32'h0000_00A2);
        offer(2, 4'd3, 32'h0000_00A3);
        #1;
        chk_cnt++; if (req_ready_out !== 3'b111) $display("FAIL rr_ready got %b exp 111", req_ready_out); else pass_cnt++;
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_tag = 4'(k + 1);
            chk_cnt++; if (cdb_valid_out !== 1'b1) $display("FAIL rr_valid%0d got %b exp 1", k, cdb_valid_out); else pass_cnt++;
            chk_cnt++; if (cdb_src_out !== 2'(k)) $display("FAIL rr_src%0d got %0d exp %0d", k, cdb_src_out, k); else pass_cnt++;
            chk_cnt++; if (cdb_tag_out !== exp_tag) $display("FAIL rr_tag%0d got %0d exp %0d", k, cdb_tag_out, exp_tag); else pass_cnt++;
            chk_cnt++; if (cdb_value_out !== 32'hA1 + 32'(k)) $display("FAIL rr_value%0d got %h exp %h", k, cdb_value_out, 32'hA1 + 32'(k)); else pass_cnt++;
        end
        tick();
        chk_cnt++; if (cdb_valid_out !== 1'b0) $display("FAIL rr_drop got %b exp 0", cdb_valid_out); else pass_cnt++;
        // ptr back at 0: producer 0 must win over producer 2
        offer(0, 4'd9, 32'h99);
        offer(2, 4'd10, 32'hAA);
        tick();
        idle();
        tick();
        chk_cnt++; if (cdb_src_out !== 2'd0 || cdb_tag_out !== 4'd9) $display("FAIL rr_ptr0 got src %0d tag %0d exp src 0 tag 9", cdb_src_out, cdb_tag_out); else pass_cnt++;
        tick();
        chk_cnt++; if (cdb_src_out !== 2'd2 || cdb_tag_out !== 4'd10) $display("FAIL rr_ptr2 got src %0d tag %0d exp src 2 tag 10", cdb_src_out, cdb_tag_out); else pass_cnt++;
        tick();
        chk_cnt++; if (cdb_valid_out !== 1'b0) $display("FAIL rr_ptr_drop got %b exp 0", cdb_valid_out); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_tag;
        for (int k = 0; k < 4; k++) begin
            offer(2, 4'(8 + k), 32'h8000 + 32'(k));
            #1;
            chk_cnt++; if (req_ready_out[2] !== 1'b1) $display("FAIL b2b_ready%0d got %b exp 1", k, req_ready_out[2]); else pass_cnt++;
            tick();
            if (k > 0) begin
                exp_tag = 4'(8 + k - 1);
                chk_cnt++; if (cdb_valid_out !== 1'b1 || cdb_tag_out !== exp_tag) $display("FAIL b2b_cdb%0d got v%b tag %0d exp v1 tag %0d", k, cdb_valid_out, cdb_tag_out, exp_tag); else pass_cnt++;
            end
        end
        idle();
        tick();
        chk_cnt++; if (cdb_valid_out !== 1'b1 || cdb_tag_out !== 4'd11 || cdb_value_out !== 32'h8003) $display("FAIL b2b_last got v%b tag %0d val %h exp v1 tag 11 val 8003", cdb_valid_out, cdb_tag_out, cdb_value_out); else pass_cnt++;
        tick();
        chk_cnt++; if (cdb_valid_out !== 1'b0) $display("FAIL b2b_drop got %b exp 0", cdb_valid_out); else pass_cnt++;
    endtask

    task automatic test_flush();
        offer(0, 4'd3, 32'h33);
        offer(1, 4'd4, 32'h44);
        tick();
        idle();
        offer(2, 4'd6, 32'h66);
        rob_flush_in = 1'b1;
        #1;
        chk_cnt++; if (req_ready_out !== 3'b000) $display("FAIL flush_ready got %b exp 000", req_ready_out); else pass_cnt++;
        tick();
        rob_flush_in = 1'b0;
        idle();
        chk_cnt++; if (cdb_valid_out !== 1'b0) $display("FAIL flush_valid got %b exp 0", cdb_valid_out); else pass_cnt++;
        #1;
        chk_cnt++; if (req_ready_out !== 3'b111) $display("FAIL flush_empty got %b exp 111", req_ready_out); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_cnt++; if (cdb_valid_out !== 1'b0) $display("FAIL flush_quiet%0d got v%b tag %0d exp v0", k, cdb_valid_out, cdb_tag_out); else pass_cnt++;
        end
    endtask

    task automatic test_rdy_stall();
        offer(1, 4'd7, 32'h7777);
        tick();
        idle();
        tick();
        chk_cnt++; if (cdb_valid_out !== 1'b1 || cdb_tag_out !== 4'd7) $display("FAIL stall_pre got v%b tag %0d exp v1 tag 7", cdb_valid_out, cdb_tag_out); else pass_cnt++;
        rdy_in = 1'b0;
        offer(0, 4'd12, 32'hC0C0);
        #1;
        chk_cnt++; if (req_ready_out !== 3'b000) $display("FAIL stall_ready got %b exp 000", req_ready_out); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_cnt++; if (cdb_valid_out !== 1'b1 || cdb_tag_out !== 4'd7 || cdb_value_out !== 32'h7777 || cdb_src_out !== 2'd1)
                $display("FAIL stall_hold%0d got v%b tag %0d val %h src %0d exp v1 tag 7 val 7777 src 1", k, cdb_valid_out, cdb_tag_out, cdb_value_out, cdb_src_out);
            else pass_cnt++;
        end
        rdy_in = 1'b1;
        #1;
        chk_cnt++; if (req_ready_out[0] !== 1'b1) $display("FAIL stall_resume_ready got %b exp 1", req_ready_out[0]); else pass_cnt++;
        tick();
        idle();
        chk_cnt++; if (cdb_valid_out !== 1'b0) $display("FAIL stall_gap got %b exp 0", cdb_valid_out); else pass_cnt++;
        tick();
        chk_cnt++; if (cdb_valid_out !== 1'b1 || cdb_tag_out !== 4'd12 || cdb_src_out !== 2'd0 || cdb_value_out !== 32'hC0C0)
            $display("FAIL stall_after got v%b tag %0d src %0d val %h exp v1 tag 12 src 0 val c0c0", cdb_valid_out, cdb_tag_out, cdb_src_out, cdb_value_out);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_async_reset();
        offer(0, 4'd13, 32'hD);
        offer(1, 4'd14, 32'hE);
        offer(2, 4'd15, 32'hF);
        tick();
        idle();
        tick();
        chk_cnt++; if (cdb_valid_out !== 1'b1 || cdb_tag_out !== 4'd14 || cdb_src_out !== 2'd1) $display("FAIL arst_pre got v%b tag %0d src %0d exp v1 tag 14 src 1", cdb_valid_out, cdb_tag_out, cdb_src_out); else pass_cnt++;
        #2 rst_in = 1'b1;
        #1;
        chk_cnt++; if (cdb_valid_out !== 1'b0) $display("FAIL arst_valid got %b exp 0", cdb_valid_out); else pass_cnt++;
        chk_cnt++; if (cdb_tag_out !== 4'd0) $display("FAIL arst_tag got %0d exp 0", cdb_tag_out); else pass_cnt++;
        chk_cnt++; if (req_ready_out !== 3'b000) $display("FAIL arst_ready got %b exp 000", req_ready_out); else pass_cnt++;
        #1 rst_in = 1'b0;
        #1;
        chk_cnt++; if (req_ready_out !== 3'b111) $display("FAIL arst_empty got %b exp 111", req_ready_out); else pass_cnt++;
        offer(1, 4'd0, 32'h1234_5678);
        offer(2, 4'd9, 32'h9);
        tick();
        idle();
        tick();
        chk_cnt++; if (cdb_valid_out !== 1'b1 || cdb_src_out !== 2'd1 || cdb_tag_out !== 4'd0 || cdb_value_out !== 32'h1234_5678)
            $display("FAIL arst_first got v%b src %0d tag %0d val %h exp v1 src 1 tag 0 val 12345678", cdb_valid_out, cdb_src_out, cdb_tag_out, cdb_value_out);
        else pass_cnt++;
        tick();
        chk_cnt++; if (cdb_valid_out !== 1'b1 || cdb_src_out !== 2'd2 || cdb_tag_out !== 4'd9) $display("FAIL arst_second got v%b src %0d tag %0d exp v1 src 2 tag 9", cdb_valid_out, cdb_src_out, cdb_tag_out); else pass_cnt++;
        tick();
        chk_cnt++; if (cdb_valid_out !== 1'b0) $display("FAIL arst_quiet got v%b tag %0d exp v0", cdb_valid_out, cdb_tag_out); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_flush();
        test_rdy_stall();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
